// File: rtl/operand_entry_fsm.sv
// Operand entry front-end for the 2-bit switch adder: synchronizes switches, debounces
// ENTER/CLEAR and captures A then B. Define LOAD_COUNT_EN to add the load_count output.
module operand_entry_fsm #(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic [WIDTH-1:0] swt,
    input  logic             btn_enter,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             operands_valid,
`ifdef LOAD_COUNT_EN
    output logic [7:0]       load_count,
`endif
    output logic [1:0]       state_led
);

    typedef enum logic [1:0] {
        StLoadA = 2'b01,
        StLoadB = 2'b10,
        StReady = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] DbLast = CNT_W'(DB_CYCLES - 1);

    // Bit 0 is ENTER, bit 1 is CLEAR.
    logic [1:0]            btn_raw;
    logic [1:0]            btn_meta_q, btn_sync_q;
    logic [1:0]            btn_stable_q, btn_stable_d, btn_prev_q;
    logic [1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]            press;
    logic                  enter_press, clear_press;

    logic [WIDTH-1:0] swt_meta_q, swt_sync_q;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             valid_q, valid_d;
`ifdef LOAD_COUNT_EN
    logic [7:0]       count_q, count_d;
`endif

    assign btn_raw = {btn_clear, btn_enter};

    always_comb begin
        btn_stable_d = btn_stable_q;
        db_cnt_d     = '0;
        for (int i = 0; i < 2; i++) begin
            if (btn_sync_q[i] != btn_stable_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    btn_stable_d[i] = btn_sync_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Rising edge of the debounced level only; release produces nothing.
    assign press       = btn_stable_q & ~btn_prev_q;
    assign enter_press = press[0];
    assign clear_press = press[1];

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            btn_meta_q   <= '0;
            btn_sync_q   <= '0;
            btn_stable_q <= '0;
            btn_prev_q   <= '0;
            db_cnt_q     <= '0;
            swt_meta_q   <= '0;
            swt_sync_q   <= '0;
        end else begin
            btn_meta_q   <= btn_raw;
            btn_sync_q   <= btn_meta_q;
            btn_stable_q <= btn_stable_d;
            btn_prev_q   <= btn_stable_q;
            db_cnt_q     <= db_cnt_d;
            swt_meta_q   <= swt;
            swt_sync_q   <= swt_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
`ifdef LOAD_COUNT_EN
        count_d = count_q;
`endif
        // CLEAR outranks a simultaneous ENTER, which is dropped.
        if (clear_press) begin
            state_d = StLoadA;
            a_d     = '0;
            b_d     = '0;
            valid_d = 1'b0;
`ifdef LOAD_COUNT_EN
            count_d = '0;
`endif
        end else if (enter_press) begin
            unique case (state_q)
                StLoadA: begin
                    a_d     = swt_sync_q;
                    state_d = StLoadB;
                end
                StLoadB: begin
                    b_d     = swt_sync_q;
                    valid_d = 1'b1;
                    state_d = StReady;
`ifdef LOAD_COUNT_EN
                    count_d = count_q + 8'd1;
`endif
                end
                StReady: begin
                    a_d     = swt_sync_q;
                    valid_d = 1'b0;
                    state_d = StLoadB;
                end
                default: state_d = StLoadA;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= StLoadA;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
`ifdef LOAD_COUNT_EN
            count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
`ifdef LOAD_COUNT_EN
            count_q <= count_d;
`endif
        end
    end

    assign a              = a_q;
    assign b              = b_q;
    assign operands_valid = valid_q;
    assign state_led      = state_q;
`ifdef LOAD_COUNT_EN
    assign load_count     = count_q;
`endif

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Directed bench for operand_entry_fsm with DB_CYCLES=4; covers load_count when
// LOAD_COUNT_EN is defined.
module tb_operand_entry_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] swt;
    logic       btn_enter, btn_clear;
    logic [1:0] a, b, state_led;
    logic       operands_valid;
`ifdef LOAD_COUNT_EN
    logic [7:0] load_count;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    operand_entry_fsm #(
        .WIDTH    (2),
        .DB_CYCLES(4),
        .CNT_W    (4)
    ) dut (
        .CLK100MHZ     (clk),
        .CPU_RESETN    (rst_n),
        .swt           (swt),
        .btn_enter     (btn_enter),
        .btn_clear     (btn_clear),
        .a             (a),
        .b             (b),
        .operands_valid(operands_valid),
`ifdef LOAD_COUNT_EN
        .load_count    (load_count),
`endif
        .state_led     (state_led)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press_enter();
        btn_enter = 1'b1;
        tick(8);
        btn_enter = 1'b0;
        tick(10);
    endtask

    task automatic check_outs(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                              input logic ev, input logic [1:0] es);
        check({tag, ".a"}, 32'(a), 32'(ea));
        check({tag, ".b"}, 32'(b), 32'(eb));
        check({tag, ".valid"}, 32'(operands_valid), 32'(ev));
        check({tag, ".state"}, 32'(state_led), 32'(es));
    endtask

    initial begin
        rst_n     = 1'b0;
        swt       = 2'b00;
        btn_enter = 1'b0;
        btn_clear = 1'b0;

        // Reset then idle
        tick(3);
        check_outs("rst_hold", 2'd0, 2'd0, 1'b0, 2'b01);
        rst_n = 1'b1;
        tick(3);
        check_outs("rst_idle", 2'd0, 2'd0, 1'b0, 2'b01);

        // Capture A: output must change exactly on the 7th edge after the raw rise
        swt       = 2'b10;
        btn_enter = 1'b1;
        tick(6);
        check_outs("a_early", 2'd0, 2'd0, 1'b0, 2'b01);
        tick(1);
        check_outs("a_cap", 2'd2, 2'd0, 1'b0, 2'b10);
        tick(3);
        btn_enter = 1'b0;
        tick(10);
        check_outs("a_held_once", 2'd2, 2'd0, 1'b0, 2'b10);
        swt = 2'b01;
        tick(5);
        check("swt_no_press", 32'(a), 32'd2);

        // Capture B
        swt = 2'b11;
        press_enter();
        check_outs("b_cap", 2'd2, 2'd3, 1'b1, 2'b11);

        // Short glitches are rejected
        repeat (5) begin
            btn_enter = 1'b1;
            tick(2);
            btn_enter = 1'b0;
            tick(2);
        end
        tick(8);
        check_outs("glitch", 2'd2, 2'd3, 1'b1, 2'b11);

        // Re-entry from READY with a steady 8-cycle hold
        swt       = 2'b01;
        btn_enter = 1'b1;
        tick(6);
        check_outs("reent_early", 2'd2, 2'd3, 1'b1, 2'b11);
        tick(1);
        check_outs("reent", 2'd1, 2'd3, 1'b0, 2'b10);
        tick(1);
        btn_enter = 1'b0;
        tick(10);
        check_outs("reent_once", 2'd1, 2'd3, 1'b0, 2'b10);

        // Clear and enter together: clear wins
        swt       = 2'b10;
        btn_clear = 1'b1;
        btn_enter = 1'b1;
        tick(10);
        btn_clear = 1'b0;
        btn_enter = 1'b0;
        tick(10);
        check_outs("clear_prio", 2'd0, 2'd0, 1'b0, 2'b01);

        // Async reset in the middle of a debounce
        swt = 2'b11;
        press_enter();
        check_outs("pre_rst", 2'd3, 2'd0, 1'b0, 2'b10);
        btn_enter = 1'b1;
        tick(2);
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 2'd0, 2'd0, 1'b0, 2'b01);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check_outs("post_rst_early", 2'd0, 2'd0, 1'b0, 2'b01);
        tick(1);
        check_outs("post_rst_cap", 2'd3, 2'd0, 1'b0, 2'b10);
        btn_enter = 1'b0;
        tick(10);

`ifdef LOAD_COUNT_EN
        btn_clear = 1'b1;
        tick(8);
        btn_clear = 1'b0;
        tick(10);
        check("cnt_clear", 32'(load_count), 32'd0);
        check("cnt_clear_state", 32'(state_led), 32'b01);
        for (int i = 0; i < 256; i++) begin
            swt = 2'b01;
            press_enter();
            swt = 2'b10;
            press_enter();
            if (i == 0) check("cnt_one", 32'(load_count), 32'd1);
        end
        check("cnt_wrap", 32'(load_count), 32'd0);
        check_outs("cnt_final", 2'd1, 2'd2, 1'b1, 2'b11);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/operand_entry_fsm.md
Name: operand_entry_fsm

Overview:
- Upstream input stage for the 2-bit + 2-bit switch adder on the Nexys4 DDR board.
- Synchronizes the slide switches and debounces two pushbuttons.
- Captures operand A, then operand B, from the same switch bank on successive ENTER presses.
- Presents the stable registered operands a/b, plus a valid flag, to the adder's global inputs.

Parameters:
- WIDTH, 2, operand width in bits; swt, a and b are all this width.
- DB_CYCLES, 1000000, cycles a synchronized button level must hold before it is accepted (10 ms at 100 MHz). Benches use 4.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz
- CPU_RESETN  input  1  asynchronous active-low reset
- swt  input  WIDTH  raw slide switches, shared operand source
- btn_enter  input  1  raw ENTER pushbutton (BTNC), active-high
- btn_clear  input  1  raw CLEAR pushbutton (BTNU), active-high
- a  output  WIDTH  registered operand A, to adder a-inputs
- b  output  WIDTH  registered operand B, to adder b-inputs
- operands_valid  output  1  high while both operands are captured
- state_led  output  2  FSM state encoding for LEDs

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (CPU_RESETN). All flops clear immediately on CPU_RESETN low; release is taken on a clock edge.
  - Reset values: a=0, b=0, operands_valid=0, state=LOAD_A, state_led=2'b01. Synchronizers, debounce counters and stable levels all reset to 0.
- Synchronization:
  - swt, btn_enter and btn_clear each pass through a 2-flop synchronizer.
  - swt is not debounced; its synchronized value is sampled only at a press.
- Debounce, per button:
  - Counter clears whenever the synchronized level equals the stable level.
  - Otherwise the counter increments.
  - When the counter reaches DB_CYCLES-1, the stable level takes the synchronized level and the counter clears.
  - Glitches shorter than DB_CYCLES cycles never change the stable level.
- Press pulse:
  - One-cycle pulse on a stable 0->1 transition only.
  - A held button gives exactly one pulse; release gives none.
- Latency:
  - Raw button high to press pulse: 2 sync cycles + DB_CYCLES cycles.
  - Press pulse to an updated a/b/valid output: 1 clock.
- FSM states and transitions:
  - LOAD_A (2'b01): on enter, a<=swt_sync and go to LOAD_B.
  - LOAD_B (2'b10): on enter, b<=swt_sync, operands_valid<=1, and go to READY.
  - READY (2'b11): on enter, a<=swt_sync, operands_valid<=0, and go to LOAD_B. b holds its old value until overwritten.
- Clear:
  - A clear pulse in any state forces state LOAD_A, a=0, b=0, operands_valid=0.
  - If clear and enter pulse in the same cycle, clear wins and the enter is dropped.
- Output hold:
  - Outputs change only on press pulses or reset.
  - Switch movement without a press never alters a or b.
- Reset mid-operation: any debounce or FSM progress is discarded; entry restarts at LOAD_A.
- state_led == 2'b00 never occurs outside the reset assertion window.

Optional Feature:
- Macro: LOAD_COUNT_EN.
- Defined:
  - Adds output port load_count [7:0], reset 0.
  - Increments by 1 on each LOAD_B->READY transition and wraps 255->0.
  - Cleared to 0 by a clear pulse.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan (DB_CYCLES=4):
- Reset then idle: CPU_RESETN low for 3 cycles, then high -> a=0, b=0, operands_valid=0, state_led=01.
- Basic entry:
  - Set swt=2'b10 and hold btn_enter high for 10 cycles -> a=2'b10, state_led=10.
  - Set swt=2'b11 and press again -> b=2'b11, operands_valid=1, state_led=11.
- Debounce reject: btn_enter high for 2 cycles, low for 2, repeated 5 times -> no pulse, state unchanged. A steady 8-cycle hold then gives exactly one pulse, 6 cycles after the rise.
- Re-entry from READY: with a=2, b=3, set swt=2'b01 and press -> a=1, b=3, operands_valid=0, state_led=10.
- Clear priority: btn_clear and btn_enter rise together and both held 10 cycles -> a=0, b=0, state_led=01, no capture.
- Async reset mid-debounce: assert CPU_RESETN low 2 cycles into an ENTER hold -> outputs are reset values immediately, with no pulse after release until a fresh full hold. Under LOAD_COUNT_EN, 256 complete A/B entries -> load_count reads 0.
